// File: rtl/ysyx_25040105_pkg.sv
// rtl/ysyx_25040105_pkg.sv - shared widths, write-back request type and source encodings
package ysyx_25040105_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_req_t;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25040105_wb_rr_arb.sv
// rtl/ysyx_25040105_wb_rr_arb.sv - 2-way round-robin arbiter between ALU and LSU results
module ysyx_25040105_wb_rr_arb
    import ysyx_25040105_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic alu_valid_i,
    input  logic lsu_valid_i,
    output logic alu_gnt_o,
    output logic lsu_gnt_o
);

    logic last_grant_q;

    // Under contention the source that was not served last wins.
    always_comb begin
        alu_gnt_o = alu_valid_i && (!lsu_valid_i || (last_grant_q == SRC_LSU));
        lsu_gnt_o = lsu_valid_i && (!alu_valid_i || (last_grant_q == SRC_ALU));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= SRC_ALU;
        end else if (alu_gnt_o) begin
            last_grant_q <= SRC_ALU;
        end else if (lsu_gnt_o) begin
            last_grant_q <= SRC_LSU;
        end
    end

endmodule

// File: rtl/ysyx_25040105_wb_arbiter.sv
// rtl/ysyx_25040105_wb_arbiter.sv - write-back arbiter, register write port and pending-write scoreboard
module ysyx_25040105_wb_arbiter
    import ysyx_25040105_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    output logic                  issue_ready_o,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [ADDR_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0]  cnt_q [NREG];
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  err_q;

    logic                  alu_gnt;
    logic                  lsu_gnt;
    logic                  acc;
    logic [ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  inc_en;
    logic                  dec_en;
    logic                  any_pend;

    ysyx_25040105_wb_rr_arb u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .lsu_valid_i (lsu_valid_i),
        .alu_gnt_o   (alu_gnt),
        .lsu_gnt_o   (lsu_gnt)
    );

    always_comb begin
        acc      = alu_gnt || lsu_gnt;
        acc_rd   = lsu_gnt ? lsu_rd_i   : alu_rd_i;
        acc_data = lsu_gnt ? lsu_data_i : alu_data_i;

        issue_ready_o = !((issue_rd_i != '0) && (cnt_q[issue_rd_i] == CNT_MAX));
        inc_en        = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
        // A retire against an empty counter is the error case; it must not wrap.
        dec_en        = rf_wen_q && (cnt_q[rf_waddr_q] != '0);

        rs1_busy_o = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
        rs2_busy_o = (rs2_i != '0) && (cnt_q[rs2_i] != '0);

        any_pend = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            any_pend = any_pend || (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_en && (issue_rd_i == ADDR_WIDTH'(r)) &&
                    !(dec_en && (rf_waddr_q == ADDR_WIDTH'(r)))) begin
                    cnt_q[r] <= cnt_q[r] + CNT_WIDTH'(1);
                end else if (dec_en && (rf_waddr_q == ADDR_WIDTH'(r)) &&
                             !(inc_en && (issue_rd_i == ADDR_WIDTH'(r)))) begin
                    cnt_q[r] <= cnt_q[r] - CNT_WIDTH'(1);
                end
            end

            rf_wen_q <= acc && (acc_rd != '0);
            if (acc && (acc_rd != '0)) begin
                rf_waddr_q <= acc_rd;
                rf_wdata_q <= acc_data;
                if (cnt_q[acc_rd] == '0) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;
    assign rf_wen_o    = rf_wen_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign err_o       = err_q;
    assign idle_o      = !any_pend && !rf_wen_q;

endmodule

// File: tb/tb_ysyx_25040105_wb_arbiter.sv
// tb/tb_ysyx_25040105_wb_arbiter.sv - directed self-checking bench for the write-back arbiter
module tb_ysyx_25040105_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_ready_o;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        idle_o;
    logic        err_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0] a_rd [3]     = '{5'd11, 5'd13, 5'd15};
    logic [4:0] l_rd [2]     = '{5'd12, 5'd14};
    bit         exp_alu [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] exp_waddr [5] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    int ai;
    int li;

    always #5 clk_i = ~clk_i;

    ysyx_25040105_wb_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .alu_valid_i   (alu_valid_i),
        .alu_ready_o   (alu_ready_o),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .rf_wen_o      (rf_wen_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .idle_o        (idle_o),
        .err_o         (err_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        issue_valid_i = 1'b0; issue_rd_i = '0;
        rs1_i = '0; rs2_i = '0;
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
        cyc(); cyc();
        rst_i = 1'b0;
        settle();
        check("rst_wen",   rf_wen_o, 0);
        check("rst_waddr", rf_waddr_o, 0);
        check("rst_wdata", rf_wdata_o, 0);
        check("rst_err",   err_o, 0);
        check("rst_idle",  idle_o, 1);
        check("rst_issue_rdy", issue_ready_o, 1);
        check("rst_alu_rdy",   alu_ready_o, 0);

        // single ALU write to x5
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        settle();
        check("t1_issue_rdy", issue_ready_o, 1);
        cyc();
        issue_valid_i = 1'b0; rs1_i = 5'd5;
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        settle();
        check("t1_busy_pre", rs1_busy_o, 1);
        check("t1_idle_pre", idle_o, 0);
        check("t1_alu_rdy",  alu_ready_o, 1);
        cyc();
        alu_valid_i = 1'b0;
        settle();
        check("t1_wen",   rf_wen_o, 1);
        check("t1_waddr", rf_waddr_o, 5);
        check("t1_wdata", rf_wdata_o, 32'hDEADBEEF);
        check("t1_busy_retire_cycle", rs1_busy_o, 1);
        cyc();
        check("t1_busy_post", rs1_busy_o, 0);
        check("t1_wen_post",  rf_wen_o, 0);
        check("t1_wdata_hold", rf_wdata_o, 32'hDEADBEEF);
        check("t1_idle_post", idle_o, 1);
        check("t1_err", err_o, 0);

        // LSU-only write to x10 leaves LSU as last grant
        issue_valid_i = 1'b1; issue_rd_i = 5'd10;
        cyc();
        issue_valid_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'h0000_000A;
        settle();
        check("t2_lsu_rdy", lsu_ready_o, 1);
        cyc();
        lsu_valid_i = 1'b0;
        check("t2_waddr", rf_waddr_o, 10);
        cyc();

        // contention: ALU carries x11,x13,x15; LSU carries x12,x14
        for (int k = 11; k <= 15; k++) begin
            issue_valid_i = 1'b1; issue_rd_i = 5'(k);
            cyc();
        end
        issue_valid_i = 1'b0;
        ai = 0; li = 0;
        for (int k = 0; k < 5; k++) begin
            alu_valid_i = (ai < 3);
            alu_rd_i    = a_rd[(ai < 3) ? ai : 2];
            alu_data_i  = 32'hC0DE_0000 | 32'(alu_rd_i);
            lsu_valid_i = (li < 2);
            lsu_rd_i    = l_rd[(li < 2) ? li : 1];
            lsu_data_i  = 32'hC0DE_0000 | 32'(lsu_rd_i);
            settle();
            check("cont_alu_rdy", alu_ready_o, exp_alu[k]);
            check("cont_lsu_rdy", lsu_ready_o, !exp_alu[k]);
            cyc();
            if (exp_alu[k]) ai++; else li++;
            check("cont_wen",   rf_wen_o, 1);
            check("cont_waddr", rf_waddr_o, exp_waddr[k]);
            check("cont_wdata", rf_wdata_o, 32'hC0DE_0000 | 32'(exp_waddr[k]));
        end
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        cyc();
        check("cont_idle", idle_o, 1);
        check("cont_err",  err_o, 0);

        // x0: issue and write are both harmless
        issue_valid_i = 1'b1; issue_rd_i = 5'd0; rs1_i = 5'd0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h1234;
        settle();
        check("x0_issue_rdy", issue_ready_o, 1);
        check("x0_alu_rdy",   alu_ready_o, 1);
        cyc();
        issue_valid_i = 1'b0; alu_valid_i = 1'b0;
        settle();
        check("x0_wen",   rf_wen_o, 0);
        check("x0_wdata_hold", rf_wdata_o, 32'hC0DE_000F);
        check("x0_waddr_hold", rf_waddr_o, 15);
        check("x0_busy",  rs1_busy_o, 0);
        check("x0_idle",  idle_o, 1);
        check("x0_err",   err_o, 0);

        // saturation on x7
        for (int k = 0; k < 3; k++) begin
            issue_valid_i = 1'b1; issue_rd_i = 5'd7;
            settle();
            check("sat_issue_rdy", issue_ready_o, 1);
            cyc();
        end
        issue_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h77;
        settle();
        check("sat_full", issue_ready_o, 0);
        cyc();
        alu_valid_i = 1'b0;
        check("sat_retire_wen", rf_wen_o, 1);
        check("sat_retire_cycle", issue_ready_o, 0);
        cyc();
        check("sat_after_retire", issue_ready_o, 1);
        alu_valid_i = 1'b1; alu_data_i = 32'h78;
        cyc();
        alu_data_i = 32'h79;
        cyc();
        alu_valid_i = 1'b0; rs1_i = 5'd7;
        cyc();
        check("sat_drained", rs1_busy_o, 0);
        check("sat_last_data", rf_wdata_o, 32'h79);

        // simultaneous issue and retire on x9
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        cyc();
        issue_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h99;
        cyc();
        alu_valid_i = 1'b0;
        issue_valid_i = 1'b1; issue_rd_i = 5'd9; rs2_i = 5'd9;
        settle();
        check("sim_wen",   rf_wen_o, 1);
        check("sim_waddr", rf_waddr_o, 9);
        check("sim_issue_rdy", issue_ready_o, 1);
        cyc();
        issue_valid_i = 1'b0;
        check("sim_busy", rs2_busy_o, 1);
        cyc();
        check("sim_busy_hold", rs2_busy_o, 1);
        alu_valid_i = 1'b1; alu_data_i = 32'h9A;
        cyc();
        alu_valid_i = 1'b0;
        cyc();
        check("sim_drained", rs2_busy_o, 0);
        check("sim_err", err_o, 0);

        // protocol error: LSU write to x3 with nothing outstanding
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'h3333; rs1_i = 5'd3;
        settle();
        check("err_lsu_rdy", lsu_ready_o, 1);
        cyc();
        lsu_valid_i = 1'b0;
        check("err_wen",   rf_wen_o, 1);
        check("err_waddr", rf_waddr_o, 3);
        check("err_wdata", rf_wdata_o, 32'h3333);
        check("err_set",   err_o, 1);
        cyc();
        check("err_no_underflow", rs1_busy_o, 0);
        check("err_sticky", err_o, 1);
        check("err_idle",   idle_o, 1);

        // asynchronous reset mid-burst
        issue_valid_i = 1'b1; issue_rd_i = 5'd20;
        cyc();
        issue_valid_i = 1'b1; issue_rd_i = 5'd21;
        alu_valid_i = 1'b1; alu_rd_i = 5'd20; alu_data_i = 32'h2020; rs1_i = 5'd21;
        cyc();
        issue_valid_i = 1'b0; alu_valid_i = 1'b0;
        settle();
        check("ar_wen_pre",  rf_wen_o, 1);
        check("ar_busy_pre", rs1_busy_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("ar_wen",   rf_wen_o, 0);
        check("ar_err",   err_o, 0);
        check("ar_busy",  rs1_busy_o, 0);
        check("ar_waddr", rf_waddr_o, 0);
        check("ar_idle",  idle_o, 1);
        cyc();
        rst_i = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
